// File: rtl/asyncmips_pkg.sv
// Shared types and constants for the asynchronous-decode MIPS front end.
// Holds the fetch FSM state encoding, the dual-rail spacer and instruction field widths.
package asyncmips_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned IMM_W    = 16;
  localparam int unsigned JADDR_W  = 26;

  // Both rails high is the precharged (null) codeword seen by decode.
  localparam logic [XLEN-1:0] SPACER = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    PRECH,
    FETCH,
    EVAL,
    UPDATE,
    HALT
  } fetch_state_e;

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC selection: jump target, taken branch target or sequential PC.
// Jump takes priority over branch; all arithmetic wraps modulo 2^32.
module fetch_next_pc
  import asyncmips_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] ir,
  input  logic            pcsrc,
  input  logic            jump,
  output logic [XLEN-1:0] next_pc
);

  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] br_off;
  logic [XLEN-1:0] br_target;
  logic [XLEN-1:0] j_target;
  logic            unused_ir;

  assign pc_plus4  = pc + 32'd4;
  assign br_off    = {{(XLEN - IMM_W - 2){ir[IMM_W-1]}}, ir[IMM_W-1:0], 2'b00};
  assign br_target = pc_plus4 + br_off;
  assign j_target  = {pc_plus4[XLEN-1:XLEN-4], ir[JADDR_W-1:0], 2'b00};

  // Opcode bits are decoded downstream; only the address fields matter here.
  assign unused_ir = ^ir[XLEN-1:XLEN-OPCODE_W];

  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = j_target;
    end else if (pcsrc) begin
      next_pc = br_target;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage feeding a dual-rail (precharge/evaluate) decode stage.
// Sequences PRECH -> FETCH -> EVAL -> UPDATE per instruction, with a timeout into HALT.
module fetch_stage
  import asyncmips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        precharge,
  output logic [31:0] instr,
  output logic [31:0] ninstr,
  input  logic        complete,
  input  logic        pcsrc,
  input  logic        npcsrc,
  input  logic        jump,
  input  logic        njump,
  output logic [31:0] pc,
  output logic        error
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] TimeoutVal = CntW'(TIMEOUT);

  fetch_state_e    state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     ir_q, ir_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            pcsrc_q, pcsrc_d;
  logic            jump_q, jump_d;
  logic            cnt_hit;
  logic            counting;
  logic            timeout;
  logic [31:0]     next_pc;

  assign cnt_hit  = (cnt_q + 1'b1) == TimeoutVal;
  // Waiting on decode: complete stuck high while precharging, or stuck low while evaluating.
  assign counting = ((state_q == PRECH) && complete) || ((state_q == EVAL) && !complete);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= PRECH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timeout = 1'b0;
    unique case (state_q)
      PRECH: begin
        if (!complete) begin
          state_d = FETCH;
        end else if (cnt_hit) begin
          state_d = HALT;
          timeout = 1'b1;
        end
      end
      FETCH: begin
        if (imem_ack) begin
          state_d = EVAL;
        end
      end
      EVAL: begin
        if (complete) begin
          state_d = UPDATE;
        end else if (cnt_hit) begin
          state_d = HALT;
          timeout = 1'b1;
        end
      end
      UPDATE:  state_d = PRECH;
      HALT:    state_d = HALT;
      default: state_d = PRECH;
    endcase
  end

  always_comb begin
    imem_req  = 1'b0;
    precharge = 1'b1;
    instr     = SPACER;
    ninstr    = SPACER;
    unique case (state_q)
      FETCH: imem_req = 1'b1;
      EVAL, UPDATE: begin
        precharge = 1'b0;
        instr     = ir_q;
        ninstr    = ~ir_q;
      end
      default: ;
    endcase
  end

  fetch_next_pc u_next_pc (
    .pc      (pc_q),
    .ir      (ir_q),
    .pcsrc   (pcsrc_q),
    .jump    (jump_q),
    .next_pc (next_pc)
  );

  always_comb begin
    pc_d    = pc_q;
    ir_d    = ir_q;
    err_d   = err_q | timeout;
    pcsrc_d = pcsrc_q;
    jump_d  = jump_q;

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (counting) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end

    if ((state_q == FETCH) && imem_ack) begin
      ir_d = imem_rdata;
    end
    // Decisions are resolved only when the rails differ; a null codeword reads as not taken.
    if ((state_q == EVAL) && complete) begin
      pcsrc_d = pcsrc & ~npcsrc;
      jump_d  = jump & ~njump;
    end
    if (state_q == UPDATE) begin
      pc_d = next_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      pcsrc_q <= 1'b0;
      jump_q  <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      pcsrc_q <= pcsrc_d;
      jump_q  <= jump_d;
    end
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign error     = err_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: memory responder, dual-rail decode stimulus,
// and a queue of expected fetch addresses checked whenever a request appears.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        precharge;
  logic [31:0] instr;
  logic [31:0] ninstr;
  logic        complete;
  logic        pcsrc, npcsrc, jump, njump;
  logic [31:0] pc;
  logic        error;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .TIMEOUT  (255)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .precharge  (precharge),
    .instr      (instr),
    .ninstr     (ninstr),
    .complete   (complete),
    .pcsrc      (pcsrc),
    .npcsrc     (npcsrc),
    .jump       (jump),
    .njump      (njump),
    .pc         (pc),
    .error      (error)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (imem_req !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, imem_req}, 32'd1);
  endtask

  task automatic pop_addr(output logic [31:0] a);
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      a = 32'hxxxx_xxxx;
    end else begin
      a = exp_q.pop_front();
    end
  endtask

  // One instruction: respond to the fetch, check the evaluate rails, resolve decode.
  task automatic run_instr(input logic [31:0] data, input logic pcs, input logic jmp,
                           input int lat, input logic [31:0] exp_n, input logic [31:0] nxt);
    logic [31:0] a;
    wait_req("req_raised");
    pop_addr(a);
    check("imem_addr", imem_addr, a);
    check("fetch_precharge", {31'd0, precharge}, 32'd1);
    repeat (lat) @(negedge clk);
    imem_ack   = 1'b1;
    imem_rdata = data;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    check("req_drop_after_ack", {31'd0, imem_req}, 32'd0);
    check("eval_precharge", {31'd0, precharge}, 32'd0);
    check("eval_instr", instr, data);
    check("eval_ninstr", ninstr, exp_n);
    complete = 1'b1;
    pcsrc = pcs;  npcsrc = ~pcs;
    jump  = jmp;  njump  = ~jmp;
    @(negedge clk);
    complete = 1'b0;
    pcsrc = 1'b0; npcsrc = 1'b0;
    jump  = 1'b0; njump  = 1'b0;
    exp_q.push_back(nxt);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    reset = 1'b1;
    imem_ack = 1'b0;  imem_rdata = 32'h0;
    complete = 1'b0;
    pcsrc = 1'b0; npcsrc = 1'b0; jump = 1'b0; njump = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_pc", pc, 32'h0);
    check("rst_precharge", {31'd0, precharge}, 32'd1);
    check("rst_instr", instr, 32'hFFFF_FFFF);
    check("rst_ninstr", ninstr, 32'hFFFF_FFFF);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    reset = 1'b0;
    exp_q.push_back(32'h0);

    // add at 0, then sequential adds up to 0x10
    run_instr(32'h0022_1820, 1'b0, 1'b0, 0, 32'hFFDD_E7DF, 32'h4);
    run_instr(32'h0022_1820, 1'b0, 1'b0, 2, ~32'h0022_1820, 32'h8);
    run_instr(32'h0000_0000, 1'b0, 1'b0, 1, ~32'h0000_0000, 32'hC);
    run_instr(32'h0022_1820, 1'b0, 1'b0, 0, ~32'h0022_1820, 32'h10);
    // beq at 0x10 taken: 0x14 + 3*4
    run_instr(32'h1000_0003, 1'b1, 1'b0, 3, ~32'h1000_0003, 32'h20);
    // j at 0x20 with branch also resolved taken: jump must win
    run_instr(32'h0800_0010, 1'b1, 1'b1, 0, ~32'h0800_0010, 32'h40);

    // Timeout: fetch at 0x40, then hold complete low in EVAL
    wait_req("to_req");
    pop_addr(a);
    check("to_addr", imem_addr, a);
    imem_ack = 1'b1;  imem_rdata = 32'h0000_0000;
    @(negedge clk);
    imem_ack = 1'b0;
    check("to_eval", {31'd0, precharge}, 32'd0);
    repeat (10) @(negedge clk);
    imem_ack = 1'b1;  imem_rdata = 32'h1234_5678;
    @(negedge clk);
    imem_ack = 1'b0;
    check("ack_ignored_eval", instr, 32'h0000_0000);
    repeat (243) @(negedge clk);
    check("to_edge_err", {31'd0, error}, 32'd0);
    check("to_edge_eval", {31'd0, precharge}, 32'd0);
    @(negedge clk);
    check("to_error", {31'd0, error}, 32'd1);
    check("halt_precharge", {31'd0, precharge}, 32'd1);
    check("halt_ninstr", ninstr, 32'hFFFF_FFFF);
    for (int i = 0; i < 5; i++) begin
      imem_ack = i[0];
      complete = ~i[0];
      @(negedge clk);
      check("halt_req", {31'd0, imem_req}, 32'd0);
      check("halt_pc", pc, 32'h40);
      check("halt_error", {31'd0, error}, 32'd1);
    end
    imem_ack = 1'b0;
    complete = 1'b0;

    // Reset out of HALT
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst2_error", {31'd0, error}, 32'd0);
    check("rst2_pc", pc, 32'h0);
    wait_req("rst2_req");

    // Reset mid-fetch, stale ack lands in PRECH
    reset = 1'b1;
    @(negedge clk);
    check("midrst_req", {31'd0, imem_req}, 32'd0);
    check("midrst_pc", pc, 32'h0);
    reset = 1'b0;
    imem_ack = 1'b1;  imem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    imem_ack = 1'b0;
    exp_q.delete();
    exp_q.push_back(32'h0);
    run_instr(32'h0022_1820, 1'b0, 1'b0, 1, 32'hFFDD_E7DF, 32'h4);
    wait_req("post_rst_req");
    pop_addr(a);
    check("post_rst_addr", imem_addr, a);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter TIMEOUT, default 255: max cycles to wait on any decode phase before error.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 imem_req  output  1  instruction-memory request; held high until imem_ack.
REQ-006 imem_addr  output  32  word-aligned fetch address (= pc).
REQ-007 imem_ack  input  1  memory response valid for one cycle; imem_rdata sampled then.
REQ-008 imem_rdata  input  32  fetched instruction.
REQ-009 precharge  output  1  high = decode precharge phase, low = evaluate phase.
REQ-010 instr / ninstr  output  32 each  dual-rail instruction to decode stage.
REQ-011 complete  input  1  decode completion (all dual-rail outputs resolved).
REQ-012 pcsrc / npcsrc, jump / njump  input  1 each  dual-rail branch/jump decisions from decode.
REQ-013 pc  output  32  address of instruction currently held.
REQ-014 error  output  1  sticky protocol-timeout flag.

Function
REQ-015 FSM states SHALL be: PRECH, FETCH, EVAL, UPDATE, HALT.
REQ-016 PRECH: precharge=1, instr=ninstr=32'hFFFF_FFFF (spacer); exit to FETCH once complete=0 sampled.
REQ-017 FETCH: imem_req=1, imem_addr=pc, precharge stays 1; on imem_ack latch imem_rdata into ir, go EVAL next cycle.
REQ-018 EVAL: precharge=0, instr=ir, ninstr=~ir; stay until complete=1 sampled, then go UPDATE.
REQ-019 Dual-rail input valid iff pos!=neg; fetch_stage SHALL sample pcsrc/jump only in the cycle complete=1 in EVAL.
REQ-020 UPDATE (one cycle) next pc priority: jump -> {pc_plus4[31:28], ir[25:0], 2'b00}; else pcsrc -> pc_plus4 + (signext(ir[15:0])<<2); else pc_plus4; pc_plus4 = pc+4, 32-bit, wrap modulo 2^32.
REQ-021 UPDATE returns to PRECH; minimum instruction period is therefore PRECH(1)+FETCH(1 + memory latency)+EVAL(1+)+UPDATE(1).
REQ-022 A wait counter SHALL clear on every state entry and count cycles in PRECH (complete stuck high) and EVAL (complete stuck low).
REQ-023 Counter reaching TIMEOUT SHALL set error=1 and enter HALT; FETCH has no timeout.
REQ-024 HALT: precharge=1, spacer on rails, imem_req=0, pc frozen; only reset exits.
REQ-025 imem_ack outside FETCH SHALL be ignored.
REQ-026 pcsrc and jump both resolved high: jump wins.
REQ-027 imem_req SHALL drop in the cycle after imem_ack; no back-to-back requests without passing through EVAL/UPDATE.

Reset
REQ-028 On reset: state=PRECH, pc=RESET_PC, ir=0, counter=0, error=0, precharge=1, instr=ninstr=all ones, imem_req=0.
REQ-029 Reset asserted in any state (including mid-FETCH with request outstanding) SHALL take effect next edge; a later stale imem_ack SHALL be ignored unless in FETCH.

Structure
REQ-030 Shared package asyncmips_pkg SHALL hold the FSM state enum, SPACER constant (32'hFFFF_FFFF), and opcode/field width constants.
REQ-031 Next-PC arithmetic SHALL be a combinational sub-module fetch_next_pc (inputs pc, ir, pcsrc, jump; output next_pc).

Verification
REQ-032 Reset with RESET_PC=0 -> pc=0, precharge=1, instr=ninstr=FFFF_FFFF, imem_req=0, error=0.
REQ-033 pc=0, imem returns 32'h0022_1820 (add), complete with pcsrc=0/npcsrc=1, jump=0/njump=1 -> ninstr=32'hFFDD_E7DF in EVAL, next imem_addr=0x4.
REQ-034 pc=0x10, ir=32'h1000_0003 (beq), pcsrc=1/npcsrc=0 -> next imem_addr=0x20.
REQ-035 pc=0x20, ir=32'h0800_0010 (j), jump=1/njump=0 -> next imem_addr=0x40.
REQ-036 complete held 0 in EVAL for 255 cycles -> error=1, HALT, imem_req stays 0 until reset.
REQ-037 reset during FETCH before imem_ack, then ack arrives in PRECH -> ack ignored, pc=RESET_PC, normal fetch of RESET_PC follows.
